// File: rtl/sum_latch_uart_tx.sv
// Operand latch, running-sum register and multi-byte UART transmitter.
// Each save strobe latches the shared data bus into its operand register; the
// registered sum of all operands is serialised LSB byte first on every save event.
module sum_latch_uart_tx #(
   parameter int DATA_W    = 4,
   parameter int NUM_OPS   = 2,
   parameter int CLK_DIV   = 434,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic                              clk,
   input  logic                              reset_n,
   input  logic [NUM_OPS-1:0]                save_n,
   input  logic [DATA_W-1:0]                 data_input,
   output logic [DATA_W+$clog2(NUM_OPS)-1:0] sum_out,
   output logic                              uart_txd,
   output logic                              uart_tx_busy
);

   // state   | meaning
   // IDLE    | line high, waiting for a save trigger
   // START   | start bit (low) of the current byte
   // DATA    | 8 data bits, LSB first, r_bit counts them
   // PAR     | parity bit (only entered when PARITY != 0)
   // STOP    | stop bit(s), r_bit counts them; decides next byte / next set / idle
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_PAR   = 3'd3,
      ST_STOP  = 3'd4
   } state_t;

   localparam int SUM_W  = DATA_W + $clog2(NUM_OPS);
   localparam int NBYTES = (SUM_W + 7) / 8;
   localparam int SNAP_W = NBYTES * 8;
   localparam int BAUD_W = $clog2(CLK_DIV);
   localparam int BYTE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(CLK_DIV - 1);
   localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NBYTES - 1);
   localparam logic [2:0]        LAST_STOP = 3'(STOP_BITS - 1);
   localparam logic              PAR_ODD   = (PARITY == 2);

   logic [NUM_OPS-1:0] r_sync1, r_sync2, r_sync3;
   logic [NUM_OPS-1:0] w_fall;
   logic [DATA_W-1:0]  r_op [NUM_OPS];
   logic [SUM_W-1:0]   w_sum;
   logic [SUM_W-1:0]   r_sum;
   logic               r_trig1, r_trig2;

   state_t             r_state, w_state_nxt;
   logic [BAUD_W-1:0]  r_baud, w_baud_nxt;
   logic [2:0]         r_bit, w_bit_nxt;
   logic [BYTE_W-1:0]  r_byte, w_byte_nxt;
   logic [7:0]         r_shift, w_shift_nxt;
   logic               r_par, w_par_nxt;
   logic [SNAP_W-1:0]  r_snap, w_snap_nxt;
   logic               r_pending, w_pending_nxt;
   logic               w_baud_tc;

   // Two-flop synchroniser plus a third stage for falling-edge detection.
   // Reset to 1 so a strobe released at reset never looks like an edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= '1;
         r_sync2 <= '1;
         r_sync3 <= '1;
      end else begin
         r_sync1 <= save_n;
         r_sync2 <= r_sync1;
         r_sync3 <= r_sync2;
      end
   end

   assign w_fall = r_sync3 & ~r_sync2;

   // Operand registers: every strobe that fell this cycle latches the bus.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_OPS; i++) r_op[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_OPS; i++) begin
            if (w_fall[i]) r_op[i] <= data_input;
         end
      end
   end

   // Zero-extended adder tree; SUM_W is wide enough that it cannot overflow.
   always_comb begin
      w_sum = '0;
      for (int i = 0; i < NUM_OPS; i++) w_sum = w_sum + SUM_W'(r_op[i]);
   end

   // Registered sum and a trigger delayed to line up with the new sum.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sum   <= '0;
         r_trig1 <= 1'b0;
         r_trig2 <= 1'b0;
      end else begin
         r_sum   <= w_sum;
         r_trig1 <= |w_fall;
         r_trig2 <= r_trig1;
      end
   end

   assign sum_out = r_sum;

   // Transmitter state and datapath registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= ST_IDLE;
         r_baud    <= BAUD_LOAD;
         r_bit     <= '0;
         r_byte    <= '0;
         r_shift   <= '0;
         r_par     <= 1'b0;
         r_snap    <= '0;
         r_pending <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_baud    <= w_baud_nxt;
         r_bit     <= w_bit_nxt;
         r_byte    <= w_byte_nxt;
         r_shift   <= w_shift_nxt;
         r_par     <= w_par_nxt;
         r_snap    <= w_snap_nxt;
         r_pending <= w_pending_nxt;
      end
   end

   assign w_baud_tc = (r_baud == '0);

   // Next-state logic. The baud counter reloads at every bit boundary, so each
   // bit is exactly CLK_DIV cycles and nothing drifts across frames or sets.
   // The current byte always sits in r_snap[7:0]; r_snap shifts down per byte.
   always_comb begin
      w_state_nxt   = r_state;
      w_baud_nxt    = w_baud_tc ? BAUD_LOAD : r_baud - 1'b1;
      w_bit_nxt     = r_bit;
      w_byte_nxt    = r_byte;
      w_shift_nxt   = r_shift;
      w_par_nxt     = r_par;
      w_snap_nxt    = r_snap;
      w_pending_nxt = r_pending | (r_trig2 & (r_state != ST_IDLE));
      case (r_state)
         ST_IDLE: begin
            w_baud_nxt = BAUD_LOAD;
            if (r_trig2) begin
               w_state_nxt = ST_START;
               w_snap_nxt  = SNAP_W'(r_sum);
               w_byte_nxt  = '0;
               w_bit_nxt   = '0;
            end
         end
         ST_START: begin
            if (w_baud_tc) begin
               w_state_nxt = ST_DATA;
               w_shift_nxt = r_snap[7:0];
               w_par_nxt   = (^r_snap[7:0]) ^ PAR_ODD;
               w_bit_nxt   = '0;
            end
         end
         ST_DATA: begin
            if (w_baud_tc) begin
               w_shift_nxt = {1'b0, r_shift[7:1]};
               if (r_bit == 3'd7) begin
                  w_bit_nxt   = '0;
                  w_state_nxt = (PARITY != 0) ? ST_PAR : ST_STOP;
               end else begin
                  w_bit_nxt = r_bit + 1'b1;
               end
            end
         end
         ST_PAR: begin
            if (w_baud_tc) begin
               w_state_nxt = ST_STOP;
               w_bit_nxt   = '0;
            end
         end
         ST_STOP: begin
            if (w_baud_tc) begin
               if (r_bit != LAST_STOP) begin
                  w_bit_nxt = r_bit + 1'b1;
               end else if (r_byte != LAST_BYTE) begin
                  w_state_nxt = ST_START;
                  w_bit_nxt   = '0;
                  w_byte_nxt  = r_byte + 1'b1;
                  w_snap_nxt  = r_snap >> 8;
               end else if (r_pending || r_trig2) begin
                  // Pending save: start a fresh set with the current sum, no idle gap.
                  w_state_nxt   = ST_START;
                  w_bit_nxt     = '0;
                  w_byte_nxt    = '0;
                  w_snap_nxt    = SNAP_W'(r_sum);
                  w_pending_nxt = 1'b0;
               end else begin
                  w_state_nxt = ST_IDLE;
                  w_bit_nxt   = '0;
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Line level decoded from registered state; idle and stop are high.
   always_comb begin
      uart_txd = 1'b1;
      case (r_state)
         ST_START: uart_txd = 1'b0;
         ST_DATA:  uart_txd = r_shift[0];
         ST_PAR:   uart_txd = r_par;
         default:  uart_txd = 1'b1;
      endcase
   end

   assign uart_tx_busy = (r_state != ST_IDLE);

endmodule
